// File: rtl/hpi_xfer_engine.sv
// HPI read/write cycle sequencer: single-beat and burst transfers with programmable setup/strobe/hold timing.
// Optional bus-turnaround gap after read bursts when HPI_TURNAROUND_EN is defined.
module hpi_xfer_engine #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 2,
  parameter int LEN_W      = 8,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1,
  parameter int TURN_CYC   = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic              otg_hpi_cs_n,
  output logic              otg_hpi_r_n,
  output logic              otg_hpi_w_n,
  output logic [ADDR_W-1:0] otg_hpi_address,
  output logic [DATA_W-1:0] otg_hpi_data_out,
  output logic              otg_hpi_data_oe,
  input  logic [DATA_W-1:0] otg_hpi_data_in
);

  localparam int MAX_A = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_B = (HOLD_CYC > TURN_CYC) ? HOLD_CYC : TURN_CYC;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
`ifdef HPI_TURNAROUND_EN
  localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURN_CYC - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
`ifdef HPI_TURNAROUND_EN
    , TURN
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [LEN_W-1:0]   beats_q;
  logic               wr_q;
  logic               wtaken_q;
  logic               oe_q;
  logic               take;
  logic               cnt_en;
  logic               phase_end;

  // data_oe rises in the take cycle itself; oe_q keeps it up for the rest of the burst
  assign otg_hpi_data_oe = oe_q | take;

  always_comb begin
    state_d      = state_q;
    phase_end    = 1'b0;
    cnt_en       = 1'b0;
    take         = 1'b0;
    cmd_ready    = 1'b0;
    wdata_ready  = 1'b0;
    busy         = 1'b1;
    otg_hpi_cs_n = 1'b1;
    otg_hpi_r_n  = 1'b1;
    otg_hpi_w_n  = 1'b1;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_d = SETUP;
      end
      SETUP: begin
        otg_hpi_cs_n = 1'b0;
        wdata_ready  = wr_q && !wtaken_q;
        take         = wdata_ready && wdata_valid;
        // setup time only counts once the beat's write data is in hand
        cnt_en       = !wr_q || wtaken_q || take;
        if (cnt_en && cnt_q == SETUP_LAST) begin
          phase_end = 1'b1;
          state_d   = STROBE;
        end
      end
      STROBE: begin
        otg_hpi_cs_n = 1'b0;
        otg_hpi_r_n  = wr_q;
        otg_hpi_w_n  = !wr_q;
        cnt_en       = 1'b1;
        if (cnt_q == STROBE_LAST) begin
          phase_end = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        otg_hpi_cs_n = 1'b0;
        cnt_en       = 1'b1;
        if (cnt_q == HOLD_LAST) begin
          phase_end = 1'b1;
          if (beats_q != '0) state_d = SETUP;
`ifdef HPI_TURNAROUND_EN
          else if (!wr_q)    state_d = TURN;
`endif
          else               state_d = IDLE;
        end
      end
`ifdef HPI_TURNAROUND_EN
      TURN: begin
        cnt_en = 1'b1;
        if (cnt_q == TURN_LAST) begin
          phase_end = 1'b1;
          state_d   = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      cnt_q            <= '0;
      beats_q          <= '0;
      wr_q             <= 1'b0;
      wtaken_q         <= 1'b0;
      oe_q             <= 1'b0;
      otg_hpi_address  <= '0;
      otg_hpi_data_out <= '0;
      rsp_valid        <= 1'b0;
      rsp_data         <= '0;
      rsp_last         <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      if (phase_end)   cnt_q <= '0;
      else if (cnt_en) cnt_q <= cnt_q + 1'b1;
      if (state_q == IDLE && cmd_valid) begin
        wr_q            <= cmd_write;
        otg_hpi_address <= cmd_addr;
        beats_q         <= cmd_len;
        wtaken_q        <= 1'b0;
      end
      if (take) begin
        otg_hpi_data_out <= wdata;
        oe_q             <= 1'b1;
        wtaken_q         <= 1'b1;
      end
      if (state_q == STROBE && phase_end && !wr_q) begin
        rsp_data  <= otg_hpi_data_in;
        rsp_valid <= 1'b1;
        rsp_last  <= (beats_q == '0);
      end
      if (state_q == HOLD && phase_end) begin
        wtaken_q <= 1'b0;
        if (beats_q != '0) beats_q <= beats_q - 1'b1;
        else               oe_q    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/hpi_xfer_engine.md
# hpi_xfer_engine

Hardware sequencer for the OTG controller's Host Port Interface (HPI). It replaces software bit-banging of the HPI chip-select, address, strobe and data PIOs with a command-driven engine. The engine generates programmable-timing read and write cycles, with single-beat or burst transfers to one HPI register. It sits between the SoC fabric (command/write-data/response streams) and the OTG chip pins, alongside `keycode` and LED logic in the top level.

## Interface
Parameters:
- `DATA_W`, 16, HPI data width.
- `ADDR_W`, 2, HPI register address width (00 data, 01 mailbox, 10 address, 11 status).
- `LEN_W`, 8, burst length field width; a burst is `cmd_len+1` beats, so at most 2^LEN_W beats.
- `SETUP_CYC`, 2, cycles from address/CS valid to strobe assert; must be ≥1.
- `STROBE_CYC`, 3, strobe low cycles; must be ≥1.
- `HOLD_CYC`, 1, cycles after strobe release with CS/address/data held; must be ≥1.
- `TURN_CYC`, 2, bus-turnaround idle cycles; used only with `HPI_TURNAROUND_EN`; must be ≥1.

Ports:
- `clk_clk`, in, 1: single clock. All logic is on the rising edge.
- `reset_reset`, in, 1: synchronous, active-high reset.
- `cmd_valid`, in, 1 / `cmd_ready`, out, 1: command handshake.
- `cmd_write`, in, 1: 1 = write burst, 0 = read burst.
- `cmd_addr`, in, ADDR_W: HPI register address, held for the whole burst.
- `cmd_len`, in, LEN_W: number of beats minus 1.
- `wdata_valid`, in, 1 / `wdata_ready`, out, 1 / `wdata`, in, DATA_W: write-beat stream.
- `rsp_valid`, out, 1 / `rsp_data`, out, DATA_W / `rsp_last`, out, 1: read-beat response. No backpressure.
- `busy`, out, 1: high whenever the state is not IDLE.
- `otg_hpi_cs_n`, `otg_hpi_r_n`, `otg_hpi_w_n`, out, 1 each: active-low pin controls.
- `otg_hpi_address`, out, ADDR_W / `otg_hpi_data_out`, out, DATA_W / `otg_hpi_data_oe`, out, 1.
- `otg_hpi_data_in`, in, DATA_W: pin data. Driven by the chip during reads.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, and TURN (TURN exists only with the macro).
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid&&cmd_ready`, latch write, addr and len, load the beat counter, and go to SETUP.
- **SETUP**
  - `cs_n`=0 and `address`=latched addr.
  - Write: `wdata_ready`=1 until a `wdata` beat is taken. Taken data is registered onto `data_out`. `data_oe`=1 from the take cycle onward.
  - The SETUP counter only advances once the write data has been taken. With no `wdata_valid`, the engine stalls in SETUP indefinitely with strobes high.
  - Go to STROBE after SETUP_CYC counted cycles.
- **STROBE**
  - `r_n`=0 (read) or `w_n`=0 (write) for STROBE_CYC cycles.
  - Read: `otg_hpi_data_in` is registered into `rsp_data` on the edge ending the last STROBE cycle.
- **HOLD**
  - Strobes high; `cs_n`, address and `data_out`/`oe` unchanged.
  - After HOLD_CYC cycles:
    - If beats remain, decrement the counter and go to SETUP. `cs_n` stays 0 across the whole burst.
    - Otherwise release `cs_n`/`oe` and go to IDLE, or to TURN if the macro applies.
- Read responses:
  - `rsp_valid` pulses for exactly one cycle, in the first HOLD cycle of each read beat.
  - `rsp_last`=1 with the final beat's response.
- The beat counter is LEN_W bits. `cmd_len`=all-ones gives 2^LEN_W beats with no wrap error.
- Reset (including mid-burst) takes effect on the next edge:
  - State→IDLE; any burst is abandoned with no further rsp or wdata handshake.
  - Output values: `cs_n`=`r_n`=`w_n`=1, `address`=0, `data_out`=0, `data_oe`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_last`=0, `busy`=0, `wdata_ready`=0, `cmd_ready`=1.

## Timing
- Command accepted at edge T → `cs_n` low and address valid from cycle T+1.
- Unstalled beat length is SETUP_CYC+STROBE_CYC+HOLD_CYC cycles.
- Burst total is (len+1)·(that beat length) cycles. IDLE→SETUP adds no extra cycle.
- Read response latency: `rsp_valid` comes 1 cycle after the last strobe-low cycle.
- The strobe never asserts in the same cycle that `cs_n` or `address` changes. `data_oe` never changes while `w_n`=0.
- `cmd_ready` goes low the cycle after acceptance. The next command can be accepted in the first IDLE cycle after the final HOLD.

## Configuration
- `HPI_TURNAROUND_EN` defined:
  - After every read burst, the engine spends TURN_CYC cycles in TURN before returning to IDLE.
  - During TURN: `cs_n`=1, `data_oe`=0, `busy`=1, `cmd_ready`=0.
  - This prevents bus contention when the chip releases the data pins.
- `HPI_TURNAROUND_EN` undefined:
  - TURN state and TURN_CYC are absent; read bursts return directly to IDLE.
  - Write bursts are identical in both builds.

## Test plan
- **Reset values:** reset held 3 cycles mid-write-burst → next cycle all outputs at their reset values; no further `wdata_ready`.
- **Single write:** defaults, write addr=2, len=0, wdata=0x1234 already valid.
  - `cs_n` low for 6 cycles starting at T+1.
  - `w_n` low for 3 cycles starting at T+3, with `data_out`=0x1234 and `oe`=1.
- **Read burst:** read addr=0, len=3, `data_in` stepping 0xA000..0xA003 per beat.
  - Four `rsp_valid` pulses spaced 6 cycles apart with those values; `rsp_last` only on 0xA003.
  - `cs_n` stays low for 24 cycles continuously.
- **Write-data stall:** write len=1 with `wdata_valid` withheld 5 cycles on beat 1 → engine stays in SETUP with `w_n`=1 and `cs_n`=0; the beat resumes and completes correctly.
- **Maximum length:** `LEN_W`=2, `cmd_len`=3 → exactly 4 beats, then IDLE, with `busy` falling on the same edge.
- **Turnaround:** with `HPI_TURNAROUND_EN`, a read followed by a back-to-back write → `cmd_ready` low for TURN_CYC=2 extra cycles, with `oe`=0 and `cs_n`=1 during the gap. Without the macro, the write command is accepted in the first cycle after HOLD.
